// File: rtl/stepdown_pkg.sv
// Shared types and defaults for the step-down converter core state logic.
// Holds the gate-sequencer state encoding and the default timing constants.
package stepdown_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HS    = 3'd1,
        ST_DT1   = 3'd2,
        ST_LS    = 3'd3,
        ST_DT2   = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam int DEF_DT_CYC    = 2;
    localparam int DEF_SS_STEP   = 1;
    localparam int DEF_FAULT_CNT = 4;
    localparam int MIN_PERIOD    = 2 * DEF_DT_CYC + 2;

    // Shortest period that still fits two dead times, one HS and one LS cycle.
    function automatic int min_period(input int dt);
        return 2 * dt + 2;
    endfunction

endpackage

// File: rtl/stepdown_softstart.sv
// Soft-start limit register: cleared on restart, stepped (saturating) at wrap.
// Ports: CLK/RST, wrap, restart, duty in; ss_lim_nxt (next limit), ss_done out.
module stepdown_softstart
    import stepdown_pkg::*;
#(
    parameter int SS_STEP = DEF_SS_STEP
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wrap,
    input  logic       restart,
    input  logic [7:0] duty,
    output logic [7:0] ss_lim_nxt,
    output logic       ss_done
);

    logic [7:0] ss_lim_q;
    logic [7:0] ss_lim_d;
    logic [8:0] ss_sum;

    always_comb begin
        ss_sum   = {1'b0, ss_lim_q} + 9'(SS_STEP);
        ss_lim_d = ss_lim_q;
        if (restart) begin
            ss_lim_d = 8'd0;
        end else if (wrap) begin
            ss_lim_d = ss_sum[8] ? 8'hFF : ss_sum[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ss_lim_q <= 8'd0;
        end else begin
            ss_lim_q <= ss_lim_d;
        end
    end

    // The period being started uses the limit it will run under.
    assign ss_lim_nxt = ss_lim_d;
    assign ss_done    = (ss_lim_q >= duty);

endmodule

// File: rtl/stepdown_corestate_ctrl.sv
// PWM gate sequencer: HS / dead / LS / dead with soft-start, OC limit, fault.
// Ports: CLK, RST, supply pins, en, duty, period, oc, zc, fault_clr in;
//        hs_on, ls_on, state, fault, ss_done out.
module stepdown_corestate_ctrl
    import stepdown_pkg::*;
#(
    parameter int DT_CYC    = DEF_DT_CYC,
    parameter int SS_STEP   = DEF_SS_STEP,
    parameter int FAULT_CNT = DEF_FAULT_CNT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CELV,
    input  logic       CELG,
    input  logic       SUB,
    input  logic       en,
    input  logic [7:0] duty,
    input  logic [7:0] period,
    input  logic       oc,
    input  logic       zc,
    input  logic       fault_clr,
    output logic       hs_on,
    output logic       ls_on,
    output logic [2:0] state,
    output logic       fault,
    output logic       ss_done
);

    localparam int OCW = $clog2(FAULT_CNT + 1);
    localparam logic [7:0]     DT8     = 8'(DT_CYC);
    localparam logic [7:0]     MINP    = 8'(min_period(DT_CYC));
    localparam logic [2:0]     DT_LAST = 3'(DT_CYC - 1);
    localparam logic [OCW-1:0] OC_LAST = OCW'(FAULT_CNT - 1);

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     per_q, per_d;
    logic [7:0]     deff_q, deff_d;
    logic [2:0]     dt_q, dt_d;
    logic [OCW-1:0] oc_cnt_q, oc_cnt_d;
    logic           oc_hit_q, oc_hit_d;

    logic       running;
    logic       wrap;
    logic       restart;
    logic [7:0] p_clamp;
    logic [7:0] lim_hs;
    logic [7:0] d_new;
    logic [7:0] ss_nxt;
    logic       ss_done_raw;
    logic       unused_pins;

    assign unused_pins = ^{CELV, CELG, SUB};

    assign running = (state_q == ST_HS) || (state_q == ST_DT1) ||
                     (state_q == ST_LS) || (state_q == ST_DT2);
    assign wrap    = running && en && (cnt_q == per_q - 8'd1);
    assign restart = (state_q == ST_IDLE) && en;

    stepdown_softstart #(
        .SS_STEP (SS_STEP)
    ) u_ss (
        .CLK        (CLK),
        .RST        (RST),
        .wrap       (wrap),
        .restart    (restart),
        .duty       (duty),
        .ss_lim_nxt (ss_nxt),
        .ss_done    (ss_done_raw)
    );

    // Effective on-time for a period starting on this edge.
    always_comb begin
        p_clamp = (period < MINP) ? MINP : period;
        lim_hs  = p_clamp - DT8 - DT8 - 8'd1;
        d_new   = duty;
        if (ss_nxt < d_new) d_new = ss_nxt;
        if (lim_hs < d_new) d_new = lim_hs;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        deff_d   = deff_q;
        oc_cnt_d = oc_cnt_q;
        oc_hit_d = oc_hit_q;
        if (state_q == ST_FAULT) begin
            if (fault_clr && !en) begin
                state_d  = ST_IDLE;
                oc_cnt_d = '0;
            end
        end else if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = 8'd0;
            oc_cnt_d = '0;
            oc_hit_d = 1'b0;
        end else if (restart || wrap) begin
            cnt_d    = 8'd0;
            per_d    = p_clamp;
            deff_d   = d_new;
            oc_hit_d = 1'b0;
            state_d  = (d_new == 8'd0) ? ST_DT1 : ST_HS;
            if (wrap) begin
                oc_cnt_d = oc_hit_q ? oc_cnt_q + 1'b1 : '0;
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
            unique case (state_q)
                ST_HS: begin
                    if (oc) begin
                        oc_hit_d = 1'b1;
                        if (oc_cnt_q >= OC_LAST) begin
                            state_d = ST_FAULT;
                            cnt_d   = cnt_q;
                        end else begin
                            state_d = ST_DT1;
                        end
                    end else if (cnt_d == deff_q) begin
                        state_d = ST_DT1;
                    end
                end
                ST_DT1: begin
                    if (dt_q == DT_LAST) state_d = ST_LS;
                end
                ST_LS: begin
                    // zc ends LS early; DT2 then holds to the wrap.
                    if (zc || (cnt_d == per_q - DT8)) state_d = ST_DT2;
                end
                default: ;
            endcase
        end
        dt_d = ((state_q == ST_DT1) && (state_d == ST_DT1)) ?
               dt_q + 3'd1 : 3'd0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            per_q    <= 8'd0;
            deff_q   <= 8'd0;
            dt_q     <= 3'd0;
            oc_cnt_q <= '0;
            oc_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            deff_q   <= deff_d;
            dt_q     <= dt_d;
            oc_cnt_q <= oc_cnt_d;
            oc_hit_q <= oc_hit_d;
        end
    end

    assign hs_on   = (state_q == ST_HS);
    assign ls_on   = (state_q == ST_LS);
    assign fault   = (state_q == ST_FAULT);
    assign state   = state_q;
    assign ss_done = ss_done_raw && (state_q != ST_IDLE);

endmodule

// File: doc/stepdown_corestate_ctrl.md
# stepdown_corestate_ctrl

Synchronous PWM sequencer for the step-down converter core state logic. Drives the high-side and low-side gate-enable nets of the stepdown power stage through the generated nand3/inverter bricks. Generates fixed-frequency PWM with programmable duty, guaranteed dead time, soft-start ramp, cycle-by-cycle overcurrent limiting, diode emulation on zero-cross, and a latched fault state.

## Interface
- DT_CYC, 2: dead-time length in clock cycles, 1..7.
- SS_STEP, 1: soft-start limit increment per PWM period.
- FAULT_CNT, 4: consecutive overcurrent-terminated periods that latch FAULT.
- CLK  in  1  clock; only clock.
- RST  in  1  synchronous, active-high reset.
- CELV, CELG, SUB  in  1 each  supply/substrate pins; carried for the brick netlist, no functional effect.
- en  in  1  converter enable.
- duty  in  8  requested high-side on-time, in cycles.
- period  in  8  PWM period in cycles; values below 2*DT_CYC+2 are treated as 2*DT_CYC+2.
- oc  in  1  overcurrent comparator, active high, pre-synchronised.
- zc  in  1  inductor zero-cross comparator, active high, pre-synchronised.
- fault_clr  in  1  fault acknowledge.
- hs_on, ls_on  out  1 each  gate enables, decoded from the state register.
- state  out  3  IDLE=0, HS=1, DT1=2, LS=3, DT2=4, FAULT=5.
- fault  out  1  high in FAULT.
- ss_done  out  1  high once ss_lim >= duty.

## Operation
- Reset: state=IDLE, cnt=0, ss_lim=0, oc_cnt=0; all outputs 0.
- IDLE: outputs 0. On en=1, the next edge starts period 0: cnt=0, ss_lim=0.
- Period start (cnt=0): sample duty and period and hold both for the period. Compute d_eff = min(duty, ss_lim, P-2*DT_CYC-1), where P is the clamped period.
- Per period:
  - HS for cnt 0..d_eff-1; skipped when d_eff=0.
  - DT1 for DT_CYC cycles.
  - LS until cnt=P-DT_CYC-1.
  - DT2 for cnt P-DT_CYC..P-1.
  - cnt wraps P-1 -> 0.
- Soft-start: ss_lim += SS_STEP at each wrap, saturating at 255.
- oc=1 in HS: next state DT1. The period is marked OC-terminated.
  - At wrap, oc_cnt increments if the period was OC-terminated; otherwise it clears.
  - An OC event that brings oc_cnt to FAULT_CNT forces FAULT on the next edge.
- zc=1 in LS: next state DT2, which holds until the wrap (diode emulation).
- FAULT: hs_on=ls_on=0, fault=1, cnt frozen. Exit to IDLE only when fault_clr=1 and en=0. fault_clr is ignored while en=1.
- Invariants:
  - hs_on and ls_on are never both 1.
  - Every hs/ls transition passes through at least DT_CYC cycles with both 0.
- Simultaneous events:
  - en=0 overrides everything except FAULT: next state IDLE, oc_cnt cleared.
  - oc and the HS end on the same cycle count as OC.
  - RST overrides all.

## Timing
- Outputs are registered decodes of state. They change exactly one edge after the deciding condition.
- en rise sampled at edge k -> state DT1 at k+1, because ss_lim=0 makes d_eff=0 in the first period.
- oc sampled high at edge k while in HS -> hs_on=0 at k+1.
- en fall sampled at edge k -> both gates 0 at k+1.
- duty and period changes take effect only at the next cnt=0.

## Structure
- Package stepdown_pkg holds:
  - the state enum (3-bit encodings above),
  - DT_CYC/SS_STEP/FAULT_CNT defaults,
  - MIN_PERIOD = 2*DT_CYC+2.
- Sub-module stepdown_softstart holds the ss_lim register, saturating increment and ss_done compare. Its inputs are wrap and restart.
- The top holds the FSM, period counter, d_eff clamp and oc_cnt.

## Test plan
- Reset/idle: RST=1 for 3 cycles with en=1 -> all outputs 0, state=0; after release, period 0 runs with hs_on never high.
- Nominal PWM: period=20, duty=6, SS_STEP=16, DT_CYC=2. From the second period, each period shows hs_on for 6 cycles, 2 dead, ls_on for 10, 2 dead; ss_done=1.
- Duty clamp: period=20, duty=200 -> hs_on 15 cycles, DT1 2, ls_on 1, DT2 2.
- Short period: period=3 -> behaves as period 6.
- Overcurrent: oc=1 on cycle 3 of HS in 3 consecutive periods -> hs_on high 3 cycles each, no fault. A 4th consecutive period -> state=5, fault=1 one edge later, both gates 0. fault_clr with en=1 -> stays FAULT. en=0 plus fault_clr -> IDLE.
- Zero-cross and abort: zc=1 at LS cycle 4 -> ls_on falls next edge and stays 0 until wrap. en=0 mid-HS -> hs_on=0 next edge, state=0, oc_cnt=0.
